// File: rtl/uart_cmd_bridge.sv
// Byte-oriented register read/write command bridge between the UART rx/tx FIFOs
// and a simple internal register bus. Every output is registered.
module uart_cmd_bridge #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       rd_uart,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic       tx_full,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    CMD_CAP,
    ADDR_FETCH,
    ADDR_CAP,
    DATA_FETCH,
    DATA_CAP,
    BUS,
    RD_WAIT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             rd_uart_q, rd_uart_d;
  logic             wr_uart_q, wr_uart_d;
  logic [7:0]       w_data_q, w_data_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_re_q, reg_re_d;
  logic             busy_q, busy_d;
  logic             err_timeout_q, err_timeout_d;

  // Strobes default low each cycle; the inter-byte counter only survives in the fetch states.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    is_wr_d       = is_wr_q;
    rd_uart_d     = 1'b0;
    wr_uart_d     = 1'b0;
    w_data_d      = w_data_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_we_d      = 1'b0;
    reg_re_d      = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          rd_uart_d = 1'b1;
          state_d   = CMD_CAP;
        end
      end
      CMD_CAP: begin
        if (r_data == CMD_WR) begin
          is_wr_d = 1'b1;
          state_d = ADDR_FETCH;
        end else if (r_data == CMD_RD) begin
          is_wr_d = 1'b0;
          state_d = ADDR_FETCH;
        end else begin
          w_data_d = NAK_BYTE;
          state_d  = RESP;
        end
      end
      ADDR_FETCH, DATA_FETCH: begin
        if (!rx_empty) begin
          rd_uart_d = 1'b1;
          state_d   = (state_q == ADDR_FETCH) ? ADDR_CAP : DATA_CAP;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the partial packet silently: no bus access, no response byte.
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADDR_CAP: begin
        reg_addr_d = r_data;
        state_d    = is_wr_q ? DATA_FETCH : BUS;
      end
      DATA_CAP: begin
        reg_wdata_d = r_data;
        state_d     = BUS;
      end
      BUS: begin
        if (is_wr_q) begin
          reg_we_d = 1'b1;
          w_data_d = ACK_BYTE;
          state_d  = RESP;
        end else begin
          reg_re_d = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_data_d = reg_rdata;
        state_d  = RESP;
      end
      RESP: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      rd_uart_q     <= 1'b0;
      wr_uart_q     <= 1'b0;
      w_data_q      <= 8'h00;
      reg_addr_q    <= 8'h00;
      reg_wdata_q   <= 8'h00;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      rd_uart_q     <= rd_uart_d;
      wr_uart_q     <= wr_uart_d;
      w_data_q      <= w_data_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_we_q      <= reg_we_d;
      reg_re_q      <= reg_re_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign rd_uart     = rd_uart_q;
  assign wr_uart     = wr_uart_q;
  assign w_data      = w_data_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: packets are predicted by a protocol-level
// model when queued; a monitor pops and compares whenever the DUT emits an event.
module tb_uart_cmd_bridge;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err_timeout;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err_timeout(err_timeout)
  );

  // rx FIFO: head is presented on r_data, popped on the clock edge ending an rd_uart cycle
  logic [7:0] rx_mem [0:4095];
  int rx_wr = 0;
  int rx_rd = 0;
  assign rx_empty = (rx_rd == rx_wr);
  assign r_data   = rx_mem[rx_rd[11:0]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_rd <= rx_wr;
    else if (rd_uart && (rx_rd != rx_wr)) rx_rd <= rx_rd + 1;
  end

  // Register file on the bus side
  logic [7:0] regfile [0:255];
  assign reg_rdata = regfile[reg_addr];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hFB;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) regfile[i] = init_val(8'(i));
    forever begin
      @(posedge clk);
      if (reg_we) regfile[reg_addr] <= reg_wdata;
    end
  end

  // Reference model state and scoreboard queues
  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  logic [7:0] ref_mem [0:255];
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int         exp_to_q[$];

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int pop_log[$];
  int last_we_cyc = 0;
  int last_re_cyc = 0;
  int last_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wr[11:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d);
    exp_bus.push_back({1'b1, a, d});
    exp_tx.push_back(8'h06);
    ref_mem[a] = d;
    push_byte(8'h57);
    push_byte(a);
    push_byte(d);
  endtask

  task automatic send_read(input logic [7:0] a);
    exp_bus.push_back({1'b0, a, 8'h00});
    exp_tx.push_back(ref_mem[a]);
    push_byte(8'h52);
    push_byte(a);
  endtask

  task automatic send_bad(input logic [7:0] op);
    exp_tx.push_back(8'h15);
    push_byte(op);
  endtask

  task automatic drain(input bit rnd_full, input string tag);
    int n;
    n = 0;
    while (n < 3000 && !(exp_bus.size() == 0 && exp_tx.size() == 0 &&
                         exp_to_q.size() == 0 && rx_empty && !busy)) begin
      @(negedge clk);
      if (rnd_full) tx_full = ($urandom_range(0, 3) == 0);
      n++;
    end
    tx_full = 1'b0;
    check({tag, "_completed_in_budget"}, n < 3000, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_uart"}, rd_uart, 0);
    check({tag, "_wr_uart"}, wr_uart, 0);
    check({tag, "_reg_we"}, reg_we, 0);
    check({tag, "_reg_re"}, reg_re, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_wdata"}, reg_wdata, 0);
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    bit   prev_rd;
    bus_t b;
    logic [7:0] e;
    prev_rd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset_n) begin
        prev_rd = 1'b0;
        continue;
      end
      if (rd_uart) begin
        check("rd_uart_while_empty", rx_empty, 0);
        check("rd_uart_back_to_back", prev_rd, 0);
        pop_log.push_back(cyc);
      end
      prev_rd = rd_uart;
      if (wr_uart) begin
        check("wr_uart_while_full", tx_full, 0);
        check("tx_push_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) begin
          e = exp_tx.pop_front();
          check("w_data", w_data, e);
        end
        last_wr_cyc = cyc;
      end
      if (reg_we) begin
        check("reg_we_expected", (exp_bus.size() > 0) && exp_bus[0].is_wr, 1);
        if (exp_bus.size() > 0) begin
          b = exp_bus.pop_front();
          check("reg_we_addr", reg_addr, b.addr);
          check("reg_we_data", reg_wdata, b.data);
        end
        last_we_cyc = cyc;
      end
      if (reg_re) begin
        check("reg_re_expected", (exp_bus.size() > 0) && !exp_bus[0].is_wr, 1);
        if (exp_bus.size() > 0) begin
          b = exp_bus.pop_front();
          check("reg_re_addr", reg_addr, b.addr);
        end
        last_re_cyc = cyc;
      end
      if (err_timeout) begin
        check("timeout_expected", exp_to_q.size() > 0, 1);
        if (exp_to_q.size() > 0) void'(exp_to_q.pop_front());
        check("timeout_window",
              (cyc - pop_log[pop_log.size()-1] >= TO) &&
              (cyc - pop_log[pop_log.size()-1] <= TO + 2), 1);
      end
    end
  end

  // Stimulus
  initial begin
    int k0;
    int n;
    int kind;
    logic [7:0] op;
    reset_n = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    #2 reset_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed write with latency checks
    k0 = pop_log.size();
    send_write(8'h10, 8'hA5);
    drain(1'b0, "write");
    check("write_pop_count", pop_log.size() - k0, 3);
    check("write_we_latency", last_we_cyc - pop_log[k0], 6);
    check("write_ack_latency", last_wr_cyc - last_we_cyc, 1);

    // Directed read of a register preloaded with C7
    k0 = pop_log.size();
    send_read(8'h3C);
    drain(1'b0, "read");
    check("read_pop_count", pop_log.size() - k0, 2);
    check("read_resp_latency", last_wr_cyc - last_re_cyc, 2);

    // Unknown opcode followed by a normal read
    send_bad(8'h41);
    send_read(8'h01);
    drain(1'b0, "bad_opcode");

    // Backpressure on the response
    tx_full = 1'b1;
    send_write(8'h33, 8'h5C);
    n = 0;
    while (n < 100 && exp_bus.size() != 0) begin
      @(negedge clk);
      n++;
    end
    check("bp_reg_we_seen", exp_bus.size(), 0);
    repeat (20) @(negedge clk);
    check("bp_w_data_held", w_data, 8'h06);
    check("bp_busy", busy, 1);
    check("bp_no_push_yet", exp_tx.size(), 1);
    tx_full = 1'b0;
    drain(1'b0, "backpressure");

    // Inter-byte timeout, then recovery
    exp_to_q.push_back(1);
    push_byte(8'h57);
    push_byte(8'h22);
    drain(1'b0, "timeout");
    send_read(8'h22);
    drain(1'b0, "after_timeout");

    // Reset in the middle of a packet
    push_byte(8'h57);
    push_byte(8'h01);
    n = 0;
    while (n < 100 && !(rx_empty && busy)) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("midpkt_busy_before_reset", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midpkt_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_write(8'h01, 8'hFF);
    drain(1'b0, "after_reset");

    // Randomized packet batches with random tx backpressure
    for (int batch = 0; batch < 60; batch++) begin
      for (int p = 0; p < $urandom_range(1, 4); p++) begin
        kind = $urandom_range(0, 19);
        if (kind < 9) send_write(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        else if (kind < 18) send_read(8'($urandom_range(0, 15)));
        else begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
          send_bad(op);
        end
      end
      drain(1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
